// File: rtl/lpf_pkg.sv
// Shared types and defaults for the multi-channel low-pass scheduler.
// ch_t is sized for the largest supported channel count (16).
package lpf_pkg;
   localparam int DEF_NUM_CH = 4;
   localparam int DEF_DATA_W = 16;
   localparam int MAX_CH     = 16;

   typedef logic [$clog2(MAX_CH)-1:0] ch_t;

   typedef enum logic [1:0] {IDLE, REQ, CALC, NEXT} state_t;
endpackage

// File: rtl/lpf_tick.sv
// Sample-tick generator: a down-counter reloaded from div on each tick.
// With en low the counter parks at 0, so the first tick follows en rising.
module lpf_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt;

   assign tick = en && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (!en)         cnt <= '0;
      else if (cnt == '0)   cnt <= div;
      else                  cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/lpf_sched.sv
// Time-multiplexed first-order IIR low-pass, y = (3*y + x)/4, over NUM_CH
// ADC channels; one sweep per tick, one sample fetched per channel via req/ack.
module lpf_sched
   import lpf_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [15:0]               div,
   output logic                      adc_req,
   output logic [$clog2(NUM_CH)-1:0] adc_ch,
   input  logic                      adc_ack,
   input  logic [DATA_W-1:0]         adc_data,
   output logic                      y_valid,
   output logic [$clog2(NUM_CH)-1:0] y_ch,
   output logic [DATA_W-1:0]         y_data,
   output logic                      busy,
   output logic                      overrun,
   output logic                      timeout_err,
   input  logic                      clr_err
);
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam ch_t LAST_CH = ch_t'(NUM_CH - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

   state_t                         state, state_n;
   ch_t                            ch;
   logic [CH_W-1:0]                ch_idx;
   logic [WAIT_W-1:0]              wait_cnt;
   logic [DATA_W-1:0]              x;
   logic [NUM_CH-1:0][DATA_W-1:0]  chan_st;
   logic [DATA_W+1:0]              acc;
   logic [DATA_W-1:0]              y_new;
   logic                           tick;
   logic                           req_expired;

   lpf_tick #(.DIV_W(16)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .div  (div),
      .tick (tick)
   );

   assign ch_idx  = ch[CH_W-1:0];
   assign adc_req = (state == REQ);
   assign adc_ch  = ch_idx;
   assign busy    = (state != IDLE);

   // 3*s + x fits in DATA_W+2 bits; after >>2 the result always fits DATA_W
   assign acc   = {2'b00, chan_st[ch_idx]} + {1'b0, chan_st[ch_idx], 1'b0} + {2'b00, x};
   assign y_new = acc[DATA_W+1:2];

   // an ack in the final wait cycle still wins over the timeout
   assign req_expired = (state == REQ) && !adc_ack && (wait_cnt == WAIT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (tick) state_n = REQ;
         REQ: begin
            if (adc_ack)          state_n = CALC;
            else if (req_expired) state_n = NEXT;
         end
         CALC:    state_n = NEXT;
         NEXT:    state_n = (ch == LAST_CH) ? IDLE : REQ;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch          <= '0;
         wait_cnt    <= '0;
         x           <= '0;
         chan_st     <= '0;
         y_valid     <= 1'b0;
         y_ch        <= '0;
         y_data      <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         y_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  ch       <= '0;
                  wait_cnt <= '0;
               end
            end
            REQ: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (adc_ack) x <= adc_data;
            end
            CALC: begin
               chan_st[ch_idx] <= y_new;
               y_data          <= y_new;
               y_ch            <= ch_idx;
               y_valid         <= 1'b1;
            end
            NEXT: begin
               if (ch != LAST_CH) begin
                  ch       <= ch + 1'b1;
                  wait_cnt <= '0;
               end
            end
            default: ;
         endcase

         // sticky flags: a set event in the same cycle beats clr_err
         if (tick && (state != IDLE)) overrun <= 1'b1;
         else if (clr_err)            overrun <= 1'b0;

         if (req_expired)  timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;
      end
   end
endmodule

// File: doc/lpf_sched.md
Name: lpf_sched

Overview:
- Time-multiplexes one first-order IIR low-pass datapath, y = (3*y + x)/4, across NUM_CH ADC channels in the servo/power driver.
- Generates the sample tick and, on each tick, runs one sweep over all channels.
- Per channel it fetches a sample over a req/ack handshake, updates that channel's stored filter state, and emits the filtered result with a valid strobe.

Parameters:
- NUM_CH, 4, number of channels; 2..16.
- DATA_W, 16, sample and output width.
- TIMEOUT, 255, maximum cycles adc_req waits for adc_ack before the channel is skipped.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  enables the tick generator; a sweep already started always completes.
- div  in  16  sample period in clk cycles minus 1; sampled at each counter reload.
- adc_req  out  1  sample request to the ADC front end.
- adc_ch  out  $clog2(NUM_CH)  channel being requested; stable while adc_req=1.
- adc_ack  in  1  one-cycle acknowledge; adc_data is valid in the same cycle.
- adc_data  in  DATA_W  unsigned sample.
- y_valid  out  1  one-cycle strobe marking a new filtered value.
- y_ch  out  $clog2(NUM_CH)  channel of y_data.
- y_data  out  DATA_W  filtered value; held between strobes.
- busy  out  1  high while a sweep is in progress.
- overrun  out  1  sticky: a tick arrived while busy.
- timeout_err  out  1  sticky: a channel was skipped on timeout.
- clr_err  in  1  synchronous clear of overrun and timeout_err.

Behaviour:
- Reset: every output is 0; tick counter=0; all channel states=0; FSM=IDLE; channel index=0.

Tick generator:
- Down-counter. When en=1 and the counter is 0, assert tick for one cycle and reload from div.
- When en=0, hold the counter at 0 and assert no tick.
- With div=0 and en=1, a tick is asserted every cycle.

FSM states:
- IDLE: on tick, set ch=0, busy=1, go to REQ.
- REQ: adc_req=1, adc_ch=ch, wait counter counts up.
  - adc_ack=1: capture adc_data into x, go to CALC.
  - Wait counter reaches TIMEOUT with no ack: set timeout_err, leave state[ch] unchanged, go to NEXT.
  - adc_ack=1 in the same cycle the counter reaches TIMEOUT: the ack wins.
- CALC (1 cycle):
  - acc = 3*state[ch] + x, computed at DATA_W+2 bits with no truncation.
  - new = acc>>2, fits in DATA_W with no saturation needed.
  - state[ch] <= new; y_data <= new; y_ch <= ch; y_valid=1 in the following cycle.
- NEXT:
  - If ch==NUM_CH-1: go to IDLE, busy=0.
  - Else: ch=ch+1, clear the wait counter, go to REQ.

Timing:
- Latency from ack to y_valid is 2 cycles.
- Minimum sweep time is 3*NUM_CH cycles when acks are immediate.

Boundary conditions:
- adc_ack outside REQ is ignored.
- A tick while busy sets overrun and is dropped; the current sweep is not disturbed.
- If clr_err and a set event occur in the same cycle, the set wins.
- en falling mid-sweep: the sweep finishes and no new tick follows.
- rst mid-sweep: asynchronous return to the reset values; adc_req drops immediately.
- A div change mid-count takes effect at the next reload.

Decomposition:
- Shared package lpf_pkg holds:
  - the FSM state enum (IDLE, REQ, CALC, NEXT);
  - DATA_W and NUM_CH defaults;
  - the ch_t index typedef.
- Sub-module lpf_tick (the divider/tick generator with ports clk, rst, en, div, tick) is split out.
- Channel state storage stays a register array inside lpf_sched.

Test Plan:
- Reset/idle: rst pulse, en=0, 100 cycles -> all outputs 0, adc_req never asserted.
- Basic sweep: NUM_CH=4, div=49, en=1, immediate ack with data 1000 on every channel.
  - First sweep: four y_valid strobes, y_ch 0..3, y_data=250.
  - Second sweep: y_data=437; third sweep: y_data=577.
- Full-scale: all states reach 65535 with input 65535 -> y_data stays 65535 with no wrap. A following input of 0 -> 49151.
- Timeout: channel 2 never acks, TIMEOUT=255.
  - adc_req held exactly 256 cycles for channel 2, timeout_err=1, no y_valid for channel 2.
  - Channel 3 is then served; state[2] is unchanged on the next sweep.
- Overrun: div=3 with ack delayed 10 cycles -> overrun=1, sweeps never interleave. clr_err -> overrun=0 until the next dropped tick.
- Reset mid-operation: assert rst while in REQ on channel 1 -> adc_req=0 in the same cycle. After release with en=1, the sweep restarts at channel 0 with all states at 0.
